// File: rtl/cpu_bus_host_mod_if.sv
// Host-side CPU register bus bundle: command queue port, read response and card bus pins.
interface cpu_bus_host_mod_if;
  // Command channel
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  // Read response and status
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  // Card bus (tristate lives at the board top)
  logic       ce;
  logic       rw;
  logic [3:0] addr;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in;

  // Sequencer view: drives the bus, accepts commands, returns responses
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, data_in,
    output cmd_ready, rsp_valid, rsp_data, busy,
    output ce, rw, addr, data_out, data_oe
  );

  // Environment view: command source plus card-side bus model
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, data_in,
    input  cmd_ready, rsp_valid, rsp_data, busy,
    input  ce, rw, addr, data_out, data_oe
  );
endinterface

// File: rtl/cpu_bus_host_mod.sv
// Host sequencer for the 8-bit CPU register bus: queued commands, programmable
// setup/strobe/hold phases, registered bus outputs and read-data return.
module cpu_bus_host_mod #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 1,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic                cpu_clock_i,
  input  logic                reset_i,
  cpu_bus_host_mod_if.master  bus_if
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PH_W  = 4;

  // Phase counter reload values (counter counts down to zero inside a phase)
  localparam logic [PH_W-1:0] SETUP_LOAD  = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0] STROBE_LOAD = PH_W'(STROBE_CYCLES - 1);
  localparam logic [PH_W-1:0] HOLD_LOAD   = PH_W'(HOLD_CYCLES - 1);

  typedef struct packed {
    logic       write;
    logic [3:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Command queue storage and bookkeeping
  cmd_t             fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push_c;
  logic             pop_c;

  // Sequencer state
  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  cmd_t             cyc_q,   cyc_d;

  // Registered outputs
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q,      busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q,  rsp_data_d;
  logic             ce_q,        ce_d;
  logic             rw_q,        rw_d;
  logic [3:0]       addr_q,      addr_d;
  logic [7:0]       data_out_q,  data_out_d;
  logic             data_oe_q,   data_oe_d;

  // A push is only taken when the registered ready says there is room,
  // so a full queue refuses even if IDLE pops on the same edge.
  assign push_c = bus_if.cmd_valid && cmd_ready_q;

  // Queue storage: no reset needed, occupancy is tracked by count_q
  always_ff @(posedge cpu_clock_i) begin
    if (push_c) begin
      fifo_q[wr_ptr_q] <= '{write: bus_if.cmd_write,
                            addr:  bus_if.cmd_addr,
                            wdata: bus_if.cmd_wdata};
    end
  end

  // Queue pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Queue pointer and occupancy registers
  always_ff @(posedge cpu_clock_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FSM state register with phase counter and latched command
  always_ff @(posedge cpu_clock_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cyc_q   <= cyc_d;
    end
  end

  // FSM next state: IDLE pops the head, each phase reloads the shared down-counter
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pop_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop_c   = 1'b1;
          state_d = ST_SETUP;
          phase_d = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (phase_q == '0) begin
          state_d = ST_STROBE;
          phase_d = STROBE_LOAD;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      ST_STROBE: begin
        if (phase_q == '0) begin
          state_d = ST_HOLD;
          phase_d = HOLD_LOAD;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      ST_HOLD: begin
        if (phase_q == '0) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // FSM outputs: computed from the next state so every bus pin is a flop
  always_comb begin
    cyc_d       = cyc_q;
    ce_d        = 1'b0;
    rw_d        = 1'b1;
    addr_d      = '0;
    data_out_d  = '0;
    data_oe_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    cmd_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    busy_d      = (state_d != ST_IDLE) || (count_d != '0);
    if (pop_c) begin
      cyc_d = fifo_q[rd_ptr_q];
    end
    if (state_d != ST_IDLE) begin
      rw_d       = cyc_d.write;
      addr_d     = cyc_d.addr;
      data_oe_d  = cyc_d.write;
      data_out_d = cyc_d.write ? cyc_d.wdata : 8'h00;
    end
    if (state_d == ST_STROBE) begin
      ce_d = 1'b1;
    end
    // Read data is captured on the edge that ends the last strobe cycle
    if ((state_q == ST_STROBE) && (phase_q == '0) && !cyc_q.write) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = bus_if.data_in;
    end
  end

  // Output registers; ce drops on the reset edge and aborted reads never respond
  always_ff @(posedge cpu_clock_i) begin
    if (!reset_i) begin
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      ce_q        <= 1'b0;
      rw_q        <= 1'b1;
      addr_q      <= '0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      ce_q        <= ce_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign bus_if.cmd_ready = cmd_ready_q;
  assign bus_if.busy      = busy_q;
  assign bus_if.rsp_valid = rsp_valid_q;
  assign bus_if.rsp_data  = rsp_data_q;
  assign bus_if.ce        = ce_q;
  assign bus_if.rw        = rw_q;
  assign bus_if.addr      = addr_q;
  assign bus_if.data_out  = data_out_q;
  assign bus_if.data_oe   = data_oe_q;

endmodule

// File: tb/tb_cpu_bus_host_mod.sv
// Directed bench for cpu_bus_host_mod: default-timing instance plus a 2/3/2 timing instance.
module tb_cpu_bus_host_mod;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cpu_bus_host_mod_if if0 ();
  cpu_bus_host_mod_if if1 ();

  cpu_bus_host_mod #(.FIFO_DEPTH(4), .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) dut0 (
    .cpu_clock_i (clk),
    .reset_i     (rst_n),
    .bus_if      (if0.master)
  );

  cpu_bus_host_mod #(.FIFO_DEPTH(4), .SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut1 (
    .cpu_clock_i (clk),
    .reset_i     (rst_n),
    .bus_if      (if1.master)
  );

  // Card register model: reads return the stored byte while strobed, writes update it
  logic [7:0] mem0 [16] = '{8'h00, 8'h91, 8'h92, 8'h93, 8'h94, 8'h3C, 8'h96, 8'h97,
                            8'h98, 8'h99, 8'h9A, 8'h9B, 8'h9C, 8'h9D, 8'h9E, 8'h9F};
  assign if0.data_in = (if0.ce && !if0.rw) ? mem0[if0.addr] : 8'h00;
  assign if1.data_in = 8'h00;

  // Bus monitors, sampled 1 time unit after each rising edge
  logic [12:0] ev0 [64];
  int          ev0_n = 0;
  int          ce0_cyc = 0;
  int          oe0_cyc = 0;
  int          rsp0_cnt = 0;
  logic [7:0]  rsp0_last = 8'h00;
  logic [12:0] ev1 [64];
  int          ev1_n = 0;
  int          ce1_cyc = 0;

  always @(posedge clk) begin
    #1;
    if (if0.ce) begin
      ce0_cyc++;
      if (ev0_n < 64) ev0[ev0_n] = {if0.rw, if0.addr, if0.data_out};
      ev0_n++;
      if (if0.rw) mem0[if0.addr] = if0.data_out;
    end
    if (if0.data_oe) oe0_cyc++;
    if (if0.rsp_valid) begin
      rsp0_cnt++;
      rsp0_last = if0.rsp_data;
    end
    if (if1.ce) ce1_cyc++;
    if (if1.data_oe) begin
      if (ev1_n < 64) ev1[ev1_n] = {if1.ce, if1.addr, if1.data_out};
      ev1_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic w, input logic [3:0] a,
                       input logic [7:0] d);
    if (sel) begin
      if1.cmd_valid = v; if1.cmd_write = w; if1.cmd_addr = a; if1.cmd_wdata = d;
    end else begin
      if0.cmd_valid = v; if0.cmd_write = w; if0.cmd_addr = a; if0.cmd_wdata = d;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic push(input bit sel, input logic w, input logic [3:0] a, input logic [7:0] d,
                      output int waits);
    int n = 0;
    drive(sel, 1'b1, w, a, d);
    while (!(sel ? if1.cmd_ready : if0.cmd_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("push_timeout", 32'(n), 32'(0));
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 4'h0, 8'h00);
    waits = n;
  endtask

  task automatic wait_idle(input bit sel);
    int n = 0;
    @(negedge clk);
    while ((sel ? if1.busy : if0.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n >= 200), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int stall;
    int b_ev, b_ce, b_oe, b_rsp, b_ev1, b_ce1;
    logic [12:0] exp_ev;

    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ce",        32'(if0.ce), 32'(0));
    check("rst_rw",        32'(if0.rw), 32'(1));
    check("rst_addr_dout", 32'({if0.addr, if0.data_out, if0.data_oe}), 32'(0));
    check("rst_rsp",       32'({if0.rsp_valid, if0.rsp_data}), 32'(0));
    check("rst_busy_rdy",  32'({if0.busy, if0.cmd_ready}), 32'(1));
    check("rst_dut1",      32'({if1.ce, if1.rw, if1.busy, if1.cmd_ready}), 32'(4'b0101));
    rst_n = 1'b1;
    @(negedge clk);

    // Single write 0x3 <- 0xA5
    b_ev = ev0_n; b_ce = ce0_cyc; b_oe = oe0_cyc; b_rsp = rsp0_cnt;
    push(1'b0, 1'b1, 4'h3, 8'hA5, w);
    wait_idle(1'b0);
    check("wr_ce_cycles", 32'(ce0_cyc - b_ce), 32'(1));
    check("wr_oe_cycles", 32'(oe0_cyc - b_oe), 32'(3));
    check("wr_bus_event", 32'(ev0[b_ev]), 32'({1'b1, 4'h3, 8'hA5}));
    check("wr_no_rsp",    32'(rsp0_cnt - b_rsp), 32'(0));
    check("wr_busy_low",  32'(if0.busy), 32'(0));

    // Read 0x5 with cycle-accurate latency
    b_oe = oe0_cyc; b_rsp = rsp0_cnt;
    drive(1'b0, 1'b1, 1'b0, 4'h5, 8'h00);
    check("rd_ready", 32'(if0.cmd_ready), 32'(1));
    @(negedge clk);                       // after accept edge t
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    check("rd_t0", 32'({if0.ce, if0.busy}), 32'(2'b01));
    @(negedge clk);                       // after t+1: SETUP
    check("rd_setup", 32'({if0.ce, if0.rw, if0.addr, if0.data_oe}), 32'({1'b0, 1'b0, 4'h5, 1'b0}));
    @(negedge clk);                       // after t+2: STROBE
    check("rd_strobe", 32'({if0.ce, if0.rw, if0.addr}), 32'({1'b1, 1'b0, 4'h5}));
    @(negedge clk);                       // after t+3: response cycle
    check("rd_rsp", 32'({if0.ce, if0.rsp_valid, if0.rsp_data}), 32'({1'b0, 1'b1, 8'h3C}));
    @(negedge clk);                       // after t+4
    check("rd_rsp_pulse", 32'({if0.rsp_valid, if0.rsp_data, if0.busy}), 32'({1'b0, 8'h3C, 1'b0}));
    check("rd_no_oe", 32'(oe0_cyc - b_oe), 32'(0));
    check("rd_rsp_count", 32'(rsp0_cnt - b_rsp), 32'(1));

    // Queue overflow: 6 back-to-back writes into a 4-deep queue
    b_ev = ev0_n; b_ce = ce0_cyc;
    stall = 0;
    for (int i = 0; i < 6; i++) begin
      push(1'b0, 1'b1, 4'(8 + i), 8'(8'h40 + i), w);
      stall += w;
    end
    check("ovf_stall_cycles", 32'(stall), 32'(1));
    wait_idle(1'b0);
    check("ovf_ce_cycles", 32'(ce0_cyc - b_ce), 32'(6));
    for (int i = 0; i < 6; i++) begin
      exp_ev = {1'b1, 4'(8 + i), 8'(8'h40 + i)};
      check($sformatf("ovf_order_%0d", i), 32'(ev0[b_ev + i]), 32'(exp_ev));
    end

    // Interleaved W 0x1<-0x22, R 0x1, W 0x2<-0x33
    b_ev = ev0_n; b_rsp = rsp0_cnt;
    push(1'b0, 1'b1, 4'h1, 8'h22, w);
    push(1'b0, 1'b0, 4'h1, 8'h00, w);
    push(1'b0, 1'b1, 4'h2, 8'h33, w);
    wait_idle(1'b0);
    check("mix_ev0", 32'(ev0[b_ev]),     32'({1'b1, 4'h1, 8'h22}));
    check("mix_ev1", 32'(ev0[b_ev + 1]), 32'({1'b0, 4'h1, 8'h00}));
    check("mix_ev2", 32'(ev0[b_ev + 2]), 32'({1'b1, 4'h2, 8'h33}));
    check("mix_rsp_count", 32'(rsp0_cnt - b_rsp), 32'(1));
    check("mix_rsp_data",  32'(rsp0_last), 32'(8'h22));

    // Reset during STROBE of a read with two writes queued
    b_ev = ev0_n; b_rsp = rsp0_cnt;
    push(1'b0, 1'b0, 4'h5, 8'h00, w);
    push(1'b0, 1'b1, 4'h9, 8'h77, w);
    push(1'b0, 1'b1, 4'hA, 8'h78, w);
    w = 0;
    while (!if0.ce && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("abort_reach_strobe", 32'({if0.ce, if0.rw}), 32'(2'b10));
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ce_drop", 32'({if0.ce, if0.rsp_valid}), 32'(0));
    check("abort_empty", 32'({if0.busy, if0.cmd_ready}), 32'(2'b01));
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_rsp",  32'(rsp0_cnt - b_rsp), 32'(0));
    check("abort_no_more", 32'(ev0_n - b_ev), 32'(1));
    check("abort_idle",    32'({if0.busy, if0.ce}), 32'(0));

    // Stretched timing instance: setup 2, strobe 3, hold 2, write 0x7 <- 0x11
    b_ev1 = ev1_n; b_ce1 = ce1_cyc;
    push(1'b1, 1'b1, 4'h7, 8'h11, w);
    wait_idle(1'b1);
    check("long_oe_cycles", 32'(ev1_n - b_ev1), 32'(7));
    check("long_ce_cycles", 32'(ce1_cyc - b_ce1), 32'(3));
    for (int i = 0; i < 7; i++) begin
      exp_ev = {((i >= 2) && (i <= 4)) ? 1'b1 : 1'b0, 4'h7, 8'h11};
      check($sformatf("long_stable_%0d", i), 32'(ev1[b_ev1 + i]), 32'(exp_ev));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
